// File: rtl/spram_pkg.sv
// Shared constants and types for the 32K x 32 single-port RAM built from 16K x 16 tiles.
// Consumed by spram16_16k and spram_w32_d32k.
package spram_pkg;

   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NBYTE      = DATA_W / 8;
   localparam int unsigned TILE_AW    = 14;
   localparam int unsigned TILE_DW    = 16;
   localparam int unsigned TILE_DEPTH = 1 << TILE_AW;
   localparam int unsigned NBANK      = 1 << (ADDR_W - TILE_AW);
   localparam int unsigned NHALF      = DATA_W / TILE_DW;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [DATA_W-1:0]  word_t;
   typedef logic [NBYTE-1:0]   bmsk_t;
   typedef logic [TILE_AW-1:0] tile_addr_t;

   // Top address bit picks the depth bank; the rest index inside the tile.
   function automatic logic bank_of(input addr_t a);
      return a[ADDR_W-1];
   endfunction

   function automatic tile_addr_t tile_index(input addr_t a);
      return a[TILE_AW-1:0];
   endfunction

endpackage

// File: rtl/spram16_16k.sv
// 16K x 16 single-port RAM tile with two byte enables and one-cycle registered read.
// Optional SPRAM_WRITE_THRU_EN: dout shows the merged word on write cycles instead of holding.
module spram16_16k
   import spram_pkg::*;
(
   input  logic               clk,
   input  logic               ce,
   input  logic               we,
   input  logic [1:0]         mask,
   input  logic [TILE_AW-1:0] addr,
   input  logic [TILE_DW-1:0] din,
   output logic [TILE_DW-1:0] dout
);

   logic [TILE_DW-1:0] mem [TILE_DEPTH];
   logic [TILE_DW-1:0] rd_word;
   logic [TILE_DW-1:0] merged;

   assign rd_word = mem[addr];

   always_comb begin
      merged = rd_word;
      for (int i = 0; i < 2; i++) begin
         if (mask[i]) merged[8*i +: 8] = din[8*i +: 8];
      end
   end

   // Storage and data-out register are not reset: contents must survive rst_n.
   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) mem[addr] <= merged;
`ifdef SPRAM_WRITE_THRU_EN
         dout <= we ? merged : rd_word;
`else
         if (!we) dout <= rd_word;
`endif
      end
   end

endmodule

// File: rtl/spram_w32_d32k.sv
// 32K x 32 single-port RAM with byte write mask: 2 depth banks x 2 width halves of 16K x 16 tiles.
// Optional SPRAM_WRITE_THRU_EN: vo returns the merged word after a write instead of holding.
module spram_w32_d32k
   import spram_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] ai,
   input  logic [DATA_W-1:0] vi,
   input  logic [NBYTE-1:0]  bmsk,
   output logic [DATA_W-1:0] vo
);

   logic                          upd;
   logic [NBANK-1:0]              ce;
   logic [NBANK-1:0][DATA_W-1:0]  bank_dout;
   logic                          bank_q;
   logic                          vld_q;

   // upd: this access refreshes the data-out path (bank select must follow it).
`ifdef SPRAM_WRITE_THRU_EN
   assign upd = 1'b1;
`else
   assign upd = ~we;
`endif

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      // Accesses are dropped while reset is asserted.
      assign ce[b] = rst_n & (bank_of(ai) == 1'(b));

      for (genvar h = 0; h < NHALF; h++) begin : g_half
         spram16_16k u_tile (
            .clk  (clk),
            .ce   (ce[b]),
            .we   (we),
            .mask (bmsk[2*h +: 2]),
            .addr (tile_index(ai)),
            .din  (vi[TILE_DW*h +: TILE_DW]),
            .dout (bank_dout[b][TILE_DW*h +: TILE_DW])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q <= 1'b0;
         vld_q  <= 1'b0;
      end else if (upd) begin
         bank_q <= bank_of(ai);
         vld_q  <= 1'b1;
      end
   end

   // Tile outputs are not reset, so vo is forced to zero until a data-out update after reset.
   assign vo = vld_q ? bank_dout[bank_q] : '0;

endmodule

// File: tb/tb_spram_w32_d32k.sv
// Self-checking bench for spram_w32_d32k: directed scenarios plus randomized traffic vs a model.
// Honours SPRAM_WRITE_THRU_EN for the expected data-out after write cycles.
module tb_spram_w32_d32k;
   import spram_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  we = 1'b0;
   addr_t ai = '0;
   word_t vi = '0;
   bmsk_t bmsk = '0;
   word_t vo;

   int    checks = 0;
   int    errors = 0;

   word_t mem_model [int];
   word_t exp_vo = '0;

   spram_w32_d32k dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .ai    (ai),
      .vi    (vi),
      .bmsk  (bmsk),
      .vo    (vo)
   );

   always #5 clk = ~clk;

   // Drive one access at the falling edge, let the rising edge take it, update the model.
   task automatic cycle(input logic w, input addr_t a, input word_t v, input bmsk_t m);
      word_t old_w;
      word_t new_w;
      @(negedge clk);
      we = w; ai = a; vi = v; bmsk = m;
      @(posedge clk);
      #1;
      if (rst_n) begin
         old_w = mem_model.exists(int'(a)) ? mem_model[int'(a)] : '0;
         if (w) begin
            new_w = old_w;
            for (int i = 0; i < NBYTE; i++) begin
               if (m[i]) new_w[8*i +: 8] = v[8*i +: 8];
            end
            if (m != '0 || mem_model.exists(int'(a))) mem_model[int'(a)] = new_w;
`ifdef SPRAM_WRITE_THRU_EN
            exp_vo = new_w;
`endif
         end else begin
            exp_vo = old_w;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (vo !== 32'h0) begin
         errors++;
         $display("FAIL reset_vo: got %08h want 00000000", vo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_vo = '0;
   endtask

   task automatic test_basic();
      cycle(1'b1, 15'h0000, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      we = 1'b0; ai = 15'h0000; bmsk = 4'h0;
      #4;
      checks++;
      if (vo !== exp_vo) begin
         errors++;
         $display("FAIL basic_pre_edge: got %08h want %08h", vo, exp_vo);
      end
      @(posedge clk);
      #1;
      exp_vo = 32'hDEADBEEF;
      checks++;
      if (vo !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic_read: got %08h want DEADBEEF", vo);
      end
   endtask

   task automatic test_mask();
      cycle(1'b1, 15'd5, 32'h11223344, 4'hF);
      cycle(1'b1, 15'd5, 32'hAAAAAAAA, 4'b0100);
      cycle(1'b0, 15'd5, 32'h0, 4'hF);
      checks++;
      if (vo !== 32'h11AA3344) begin
         errors++;
         $display("FAIL mask_lane2: got %08h want 11AA3344", vo);
      end
      cycle(1'b1, 15'd5, 32'hFFFFFFFF, 4'h0);
      cycle(1'b0, 15'd5, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h11AA3344) begin
         errors++;
         $display("FAIL mask_none: got %08h want 11AA3344", vo);
      end
   endtask

   task automatic test_bank_boundary();
      cycle(1'b1, 15'h3FFF, 32'h0000BEEF, 4'hF);
      cycle(1'b1, 15'h4000, 32'hCAFE0000, 4'hF);
      cycle(1'b0, 15'h3FFF, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h0000BEEF) begin
         errors++;
         $display("FAIL bank_lo: got %08h want 0000BEEF", vo);
      end
      cycle(1'b0, 15'h4000, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'hCAFE0000) begin
         errors++;
         $display("FAIL bank_hi: got %08h want CAFE0000", vo);
      end
      cycle(1'b0, 15'h3FFF, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h0000BEEF) begin
         errors++;
         $display("FAIL bank_back: got %08h want 0000BEEF", vo);
      end
   endtask

   task automatic test_top_addr();
      cycle(1'b1, 15'h7FFF, 32'h12345678, 4'hF);
      cycle(1'b0, 15'h7FFF, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h12345678) begin
         errors++;
         $display("FAIL top_addr: got %08h want 12345678", vo);
      end
      cycle(1'b0, 15'h0000, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL addr0_kept: got %08h want DEADBEEF", vo);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 15'h0000, 32'h0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (vo !== 32'h0) begin
         errors++;
         $display("FAIL reset_async: got %08h want 00000000", vo);
      end
      // Writes while in reset must not land.
      cycle(1'b1, 15'h0000, 32'hFFFFFFFF, 4'hF);
      cycle(1'b0, 15'h4000, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold: got %08h want 00000000", vo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_vo = '0;
      cycle(1'b0, 15'h0000, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reset_retain: got %08h want DEADBEEF", vo);
      end
   endtask

   task automatic test_write_output();
      word_t want;
`ifdef SPRAM_WRITE_THRU_EN
      want = 32'h11AA33FF;
`else
      want = 32'h11AA3344;
`endif
      cycle(1'b0, 15'd5, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h11AA3344) begin
         errors++;
         $display("FAIL wr_out_pre: got %08h want 11AA3344", vo);
      end
      cycle(1'b1, 15'd5, 32'h000000FF, 4'b0001);
      checks++;
      if (vo !== want) begin
         errors++;
         $display("FAIL wr_out: got %08h want %08h", vo, want);
      end
      cycle(1'b0, 15'd5, 32'h0, 4'h0);
      checks++;
      if (vo !== 32'h11AA33FF) begin
         errors++;
         $display("FAIL wr_out_after: got %08h want 11AA33FF", vo);
      end
   endtask

   task automatic test_random();
      addr_t pool [20];
      pool[0] = 15'h0000; pool[1] = 15'h3FFF; pool[2] = 15'h4000; pool[3] = 15'h7FFF;
      for (int i = 4; i < 20; i++) pool[i] = addr_t'($urandom_range(0, 32767));
      for (int n = 0; n < 400; n++) begin
         addr_t a;
         logic  w;
         bmsk_t m;
         a = pool[$urandom_range(0, 19)];
         w = ($urandom_range(0, 1) == 1);
         m = bmsk_t'($urandom_range(0, 15));
         if (!mem_model.exists(int'(a))) begin
            w = 1'b1;
            m = 4'hF;
         end
         cycle(w, a, word_t'($urandom), m);
         checks++;
         if (vo !== exp_vo) begin
            errors++;
            $display("FAIL random[%0d] we=%0b a=%04h: got %08h want %08h", n, w, a, vo, exp_vo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mask();
      test_bank_boundary();
      test_top_addr();
      test_reset_mid();
      test_write_output();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
